// File: rtl/decode_hazard_stage.sv
// decode_hazard_stage: RV32I instruction decode stage with register file,
// format immediate generation, load-use / writeback hazard detection with
// bubble insertion, flush squash and downstream-stall hold.
// Optional build macro: REGFILE_BYPASS_EN forwards a same-cycle writeback
// into the register read values instead of stalling for it.
//
// Handshake: if_valid qualifies if_pc/if_instr. While stall_out is high the
// fetch side keeps if_* unchanged and nothing is consumed. stall_in high means
// execute cannot take a new ID/EX entry, so the entire ID/EX register holds.
// id_valid qualifies every other id_* output.
module decode_hazard_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            stall_in,
  input  logic            flush,
  input  logic            ex_is_load,
  input  logic [RW-1:0]   ex_rd,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_out,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic [RW-1:0]   id_rd,
  output logic [RW-1:0]   id_rs1_idx,
  output logic [RW-1:0]   id_rs2_idx,
  output logic [XLEN-1:0] id_rs1_val,
  output logic [XLEN-1:0] id_rs2_val,
  output logic [XLEN-1:0] id_imm
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [XLEN-1:0] r_regs [NREGS];

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;
  logic [RW-1:0]   r_rd;
  logic [RW-1:0]   r_rs1_idx;
  logic [RW-1:0]   r_rs2_idx;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [XLEN-1:0] r_imm;

  logic [6:0]      w_opcode;
  logic [RW-1:0]   w_rd;
  logic [RW-1:0]   w_rs1;
  logic [RW-1:0]   w_rs2;
  logic            w_rs1_used;
  logic            w_rs2_used;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_hazard;
  logic            w_wb_hazard;

  // Field extraction; register indices are narrowed to the regfile index width.
  assign w_opcode = if_instr[6:0];
  assign w_rd     = RW'(if_instr[11:7]);
  assign w_rs1    = RW'(if_instr[19:15]);
  assign w_rs2    = RW'(if_instr[24:20]);

  // U and J formats carry no rs1; only R, S and B formats read rs2.
  assign w_rs1_used = !(w_opcode == OP_LUI || w_opcode == OP_AUIPC || w_opcode == OP_JAL);
  assign w_rs2_used = (w_opcode == OP_REG || w_opcode == OP_STORE || w_opcode == OP_BRANCH);

  // Immediate selection by instruction format; unknown opcodes give zero.
  always_comb begin
    w_imm32 = '0;
    case (w_opcode)
      OP_IMM, OP_LOAD, OP_JALR:
        w_imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
      OP_STORE:
        w_imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      OP_BRANCH:
        w_imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                   if_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        w_imm32 = {if_instr[31:12], 12'h000};
      OP_JAL:
        w_imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                   if_instr[30:21], 1'b0};
      default:
        w_imm32 = '0;
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  // Combinational register reads; x0 is hard-wired to zero.
  always_comb begin
    w_rs1_val = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
    w_rs2_val = (w_rs2 == '0) ? '0 : r_regs[w_rs2];
`ifdef REGFILE_BYPASS_EN
    if (wb_we && (wb_rd != '0) && (wb_rd == w_rs1)) w_rs1_val = wb_data;
    if (wb_we && (wb_rd != '0) && (wb_rd == w_rs2)) w_rs2_val = wb_data;
`endif
  end

  assign w_hazard = if_valid && ex_is_load && (ex_rd != '0) &&
                    ((w_rs1_used && (ex_rd == w_rs1)) || (w_rs2_used && (ex_rd == w_rs2)));

`ifdef REGFILE_BYPASS_EN
  assign w_wb_hazard = 1'b0;
`else
  // Without forwarding, a read of a register being written this cycle would
  // see the stale value, so hold the instruction one cycle instead.
  assign w_wb_hazard = if_valid && wb_we && (wb_rd != '0) &&
                       ((w_rs1_used && (wb_rd == w_rs1)) || (w_rs2_used && (wb_rd == w_rs2)));
`endif

  assign stall_out = stall_in || w_hazard || w_wb_hazard;

  // Register file write port; independent of stall, flush and hazards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (wb_we && (wb_rd != '0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // ID/EX register: reset > flush > downstream hold > bubble > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_opcode  <= '0;
      r_funct3  <= '0;
      r_funct7  <= '0;
      r_rd      <= '0;
      r_rs1_idx <= '0;
      r_rs2_idx <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_imm     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (stall_in) begin
      r_valid <= r_valid;
    end else if (w_hazard || w_wb_hazard) begin
      r_valid <= 1'b0;
    end else begin
      r_valid   <= if_valid;
      r_pc      <= if_pc;
      r_opcode  <= w_opcode;
      r_funct3  <= if_instr[14:12];
      r_funct7  <= if_instr[31:25];
      r_rd      <= w_rd;
      r_rs1_idx <= w_rs1;
      r_rs2_idx <= w_rs2;
      r_rs1_val <= w_rs1_val;
      r_rs2_val <= w_rs2_val;
      r_imm     <= w_imm;
    end
  end

  assign id_valid   = r_valid;
  assign id_pc      = r_pc;
  assign id_opcode  = r_opcode;
  assign id_funct3  = r_funct3;
  assign id_funct7  = r_funct7;
  assign id_rd      = r_rd;
  assign id_rs1_idx = r_rs1_idx;
  assign id_rs2_idx = r_rs2_idx;
  assign id_rs1_val = r_rs1_val;
  assign id_rs2_val = r_rs2_val;
  assign id_imm     = r_imm;

endmodule

// File: tb/tb_decode_hazard_stage.sv
// tb_decode_hazard_stage: directed scenarios followed by randomized traffic,
// checked against a behavioural model of the decode stage.
module tb_decode_hazard_stage;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RW    = 5;
  localparam int FW    = 4 * XLEN + 7 + 3 + 7 + 3 * RW;
  localparam int W     = FW + 2;

  logic            clk;
  logic            rst;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            stall_in;
  logic            flush;
  logic            ex_is_load;
  logic [RW-1:0]   ex_rd;
  logic            wb_we;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            stall_out;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic [6:0]      id_funct7;
  logic [RW-1:0]   id_rd;
  logic [RW-1:0]   id_rs1_idx;
  logic [RW-1:0]   id_rs2_idx;
  logic [XLEN-1:0] id_rs1_val;
  logic [XLEN-1:0] id_rs2_val;
  logic [XLEN-1:0] id_imm;

  decode_hazard_stage #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .stall_in(stall_in), .flush(flush), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall_out(stall_out),
    .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode), .id_funct3(id_funct3),
    .id_funct7(id_funct7), .id_rd(id_rd), .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: architectural registers and the expected ID/EX entry.
  logic [XLEN-1:0] m_regs [NREGS];
  logic            m_valid;
  logic            m_known;
  logic [FW-1:0]   m_fields;
  logic [W-1:0]    exp_q [$];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_imm(input logic [31:0] ins);
    logic signed [31:0] s;
    logic [31:0] sign;
    s = ins;
    sign = s >>> 31;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: return s >>> 20;
      7'b0100011: return (sign << 12) | ({20'd0, ins[31:25], 5'd0}) | {27'd0, ins[11:7]};
      7'b1100011: return (sign << 12) | ({31'd0, ins[7]} << 11) | ({26'd0, ins[30:25]} << 5)
                         | ({28'd0, ins[11:8]} << 1);
      7'b0110111, 7'b0010111: return ins & 32'hFFFF_F000;
      7'b1101111: return (sign << 20) | ({24'd0, ins[19:12]} << 12) | ({31'd0, ins[20]} << 11)
                         | ({22'd0, ins[30:21]} << 1);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] model_read(input int idx);
    if (idx == 0) return '0;
    if (BYPASS && wb_we && (int'(wb_rd) == idx)) return wb_data;
    return m_regs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_valid  = 1'b0;
    m_known  = 1'b1;
    m_fields = '0;
  endtask

  // Driver/scoreboard step: inputs are already driven (at the negedge).
  // Checks stall_out, advances the model, clocks the DUT and checks id_*.
  task automatic cycle();
    logic [6:0] op;
    int rs1, rs2, exd, wbd;
    bit use1, use2, hz, whz, exp_stall;
    logic [W-1:0] e;
    #1;
    op   = if_instr[6:0];
    rs1  = int'(if_instr[19:15]);
    rs2  = int'(if_instr[24:20]);
    exd  = int'(ex_rd);
    wbd  = int'(wb_rd);
    use1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    use2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    hz   = if_valid && ex_is_load && exd != 0 && ((use1 && exd == rs1) || (use2 && exd == rs2));
    whz  = !BYPASS && if_valid && wb_we && wbd != 0 &&
           ((use1 && wbd == rs1) || (use2 && wbd == rs2));
    exp_stall = stall_in || hz || whz;
    chk("stall_out", {255'd0, stall_out}, {255'd0, exp_stall});

    if (rst) begin
      model_reset();
    end else begin
      if (flush) begin
        m_valid = 1'b0;
        m_known = 1'b0;
      end else if (stall_in) begin
        m_valid = m_valid;
      end else if (hz || whz) begin
        m_valid = 1'b0;
        m_known = 1'b0;
      end else begin
        m_valid  = if_valid;
        m_known  = 1'b1;
        m_fields = {if_pc, op, if_instr[14:12], if_instr[31:25], if_instr[11:7],
                    if_instr[19:15], if_instr[24:20], model_read(rs1), model_read(rs2),
                    model_imm(if_instr)};
      end
      if (wb_we && wbd != 0) m_regs[wbd] = wb_data;
    end
    exp_q.push_back({m_known, m_valid, m_fields});

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("id_valid", {255'd0, id_valid}, {255'd0, e[FW]});
    if (e[FW+1]) begin
      chk("id_fields",
          {96'd0, id_pc, id_opcode, id_funct3, id_funct7, id_rd, id_rs1_idx, id_rs2_idx,
           id_rs1_val, id_rs2_val, id_imm},
          {96'd0, e[FW-1:0]});
    end
    @(negedge clk);
  endtask

  task automatic drive_idle();
    rst = 0; if_valid = 0; if_pc = '0; if_instr = 32'h0000_0013;
    stall_in = 0; flush = 0; ex_is_load = 0; ex_rd = '0;
    wb_we = 0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic drive_wb(input int rd, input logic [XLEN-1:0] data);
    wb_we = 1; wb_rd = RW'(rd); wb_data = data;
  endtask

  task automatic drive_if(input logic [XLEN-1:0] pc, input logic [31:0] ins);
    if_valid = 1; if_pc = pc; if_instr = ins;
  endtask

  logic [6:0] op_tab [10];

  initial begin
    op_tab = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
               7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1111111};
    model_reset();
    drive_idle();
    @(negedge clk);

    // Reset for two cycles while a write to x5 is attempted.
    rst = 1; drive_wb(5, 32'h1234);
    cycle();
    cycle();
    chk("rst_valid", {255'd0, id_valid}, 256'd0);
    chk("rst_pc", {224'd0, id_pc}, 256'd0);

    // x5 must read zero after release: add x6,x5,x5.
    drive_idle();
    drive_if(32'h80, 32'h0052_8333);
    cycle();
    chk("x5_after_rst", {224'd0, id_rs1_val}, 256'd0);

    // Writeback x1=0x10, x2=0x20, then addi x3,x1,-1.
    drive_idle(); drive_wb(1, 32'h10); cycle();
    drive_idle(); drive_wb(2, 32'h20); cycle();
    drive_idle(); drive_if(32'h100, 32'hFFF0_8193); cycle();
    chk("flow_valid", {255'd0, id_valid}, 256'd1);
    chk("flow_pc", {224'd0, id_pc}, 256'h100);
    chk("flow_rs1", {224'd0, id_rs1_val}, 256'h10);
    chk("flow_imm", {224'd0, id_imm}, 256'hFFFF_FFFF);
    chk("flow_rd", {251'd0, id_rd}, 256'd3);

    // Load-use: add x4,x3,x2 behind a load to x3.
    drive_idle(); drive_if(32'h104, 32'h0021_8233);
    ex_is_load = 1; ex_rd = 5'd3;
    #1 chk("lu_stall", {255'd0, stall_out}, 256'd1);
    cycle();
    chk("lu_bubble", {255'd0, id_valid}, 256'd0);
    ex_is_load = 0;
    cycle();
    chk("lu_issue", {255'd0, id_valid}, 256'd1);
    chk("lu_rs2", {224'd0, id_rs2_val}, 256'h20);

    // Downstream stall for three cycles, then flush while stalled.
    for (int k = 0; k < 3; k++) begin
      drive_idle(); drive_if($urandom, {$urandom} & 32'hFFFF_FF80 | 32'h33);
      stall_in = 1;
      cycle();
      chk("stall_pc", {224'd0, id_pc}, 256'h104);
      chk("stall_valid", {255'd0, id_valid}, 256'd1);
    end
    flush = 1;
    cycle();
    chk("flush_valid", {255'd0, id_valid}, 256'd0);

    // Writes to x0 are dropped: add x5,x0,x0.
    drive_idle(); drive_wb(0, 32'hDEAD); drive_if(32'h200, 32'h0000_02B3);
    cycle();
    chk("x0_rs1", {224'd0, id_rs1_val}, 256'd0);
    chk("x0_rs2", {224'd0, id_rs2_val}, 256'd0);

    // Same-cycle writeback of x7 while add x8,x7,x0 is in IF.
    drive_idle(); drive_wb(7, 32'h55); drive_if(32'h204, 32'h0003_8433);
    cycle();
    if (BYPASS) begin
      chk("byp_rs1", {224'd0, id_rs1_val}, 256'h55);
    end else begin
      chk("nobyp_bubble", {255'd0, id_valid}, 256'd0);
      wb_we = 0;
      cycle();
      chk("nobyp_rs1", {224'd0, id_rs1_val}, 256'h55);
    end

    // Randomized traffic with small register indices to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0]   = op_tab[$urandom_range(0, 9)];
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      rst        = ($urandom_range(0, 49) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      stall_in   = ($urandom_range(0, 4) == 0);
      ex_is_load = ($urandom_range(0, 2) == 0);
      ex_rd      = RW'($urandom_range(0, 7));
      wb_we      = 1'($urandom_range(0, 1));
      wb_rd      = RW'($urandom_range(0, 7));
      wb_data    = $urandom;
      if_valid   = ($urandom_range(0, 3) != 0);
      if_pc      = $urandom;
      if_instr   = ins;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
